add_sub_array: RTL and testbench
================================

Name: add_sub_array

Overview:
- LANES-wide, pipelined modular butterfly add/sub for the NTT/INTT datapath; sits between memory read-out and the twiddle multiplier stage.
- Per lane it computes (a+b) mod Q and (a−b) mod Q; in INTT mode both results are also multiplied by 2⁻¹ mod Q.
- Mode is selected per transaction at run time, not at elaboration.
- Valid/ready handshake with full backpressure; outputs are strictly reduced to [0, Q−1].

Parameters:
- LANES, 4, number of independent butterfly lanes.
- DATA_WIDTH, `DATA_WIDTH, coefficient width; Q < 2^DATA_WIDTH.
- Q, `Q, odd modulus.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_mode  in  1  0 = NTT, 1 = INTT; sampled with the transaction.
- in_a  in  LANES x DATA_WIDTH  first operands, each in [0, Q−1].
- in_b  in  LANES x DATA_WIDTH  second operands, each in [0, Q−1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  LANES x DATA_WIDTH  (a+b) mod Q, or (a+b)/2 mod Q in INTT mode.
- out_diff  out  LANES x DATA_WIDTH  (a−b) mod Q, or (a−b)/2 mod Q in INTT mode.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_sum=0, out_diff=0, all stage valids 0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded, with no partial output.
- Pipeline: two register stages, S1 and S2.
  - Latency is exactly 2 cycles from the input handshake to out_valid when out_ready is held at 1.
  - Throughput: 1 transaction per cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Advance enable: en = !out_valid || out_ready. in_ready = en (combinational from out_ready).
  - When en=0, all stages hold.
  - out_sum and out_diff stay stable while out_valid && !out_ready.
  - Bubbles propagate as S1 valid=0. Data registers may update on bubbles but must not be observable.
- S1, per lane (widths: s is DATA_WIDTH+1 bits unsigned; d is DATA_WIDTH+1 bits signed):
  - s = a+b; if s ≥ Q then s −= Q.
  - d = a−b; if d < 0 then d += Q.
  - Register s, d and mode.
- S2, per lane:
  - NTT mode: pass s and d through unchanged.
  - INTT mode, for each x in {s, d}: if x is odd, x += Q (needs DATA_WIDTH+1 bits); then x >>= 1.
  - Results lie in [0, Q−1].
- No result may equal Q. This covers a=b=0 and a+b=Q.
- Lanes are independent. The mode is common to all lanes of one transaction.
- A mode change between back-to-back transactions needs no bubble.

Optional Feature:
- Macro: ADD_SUB_RANGE_CHECK_EN.
- When defined, output port err (out, 1) is present and sticky.
  - err is set one cycle after any accepted transaction has some lane with in_a ≥ Q or in_b ≥ Q.
  - err is cleared only by rst.
  - The datapath result for such a transaction is unspecified.
- When not defined, the port and its logic are absent and out-of-range inputs are unchecked.

Decomposition:
- Shared package (ntt_pkg) holds:
  - DATA_WIDTH and Q constants.
  - typedef coef_t (logic [DATA_WIDTH-1:0]).
  - typedef enum bf_mode_t {BF_NTT=0, BF_INTT=1}.
- Sub-module add_sub_lane: one lane's S1/S2 datapath with an enable input and no handshake logic.
- add_sub_array holds the valid/ready control and instantiates LANES copies via generate.

Test Plan (Q=3329, DATA_WIDTH=12, LANES=4):
- NTT, a=3000, b=1000 -> 2 cycles later sum=671, diff=2000. Also a=0, b=1 -> sum=1, diff=3328.
- INTT, a=3, b=0 -> sum=1666, diff=1666. INTT a=0, b=1 -> sum=1665, diff=1664.
- Boundaries: a=b=3328 in NTT -> sum=3327, diff=0. a=1664, b=1665 in NTT -> sum=0, diff=3328. No output equals 3329.
- Backpressure:
  - Stream 8 transactions with alternating modes; hold out_ready=0 for cycles 3–6.
  - Expected: in_ready drops, nothing is lost or duplicated, results arrive in order and stay stable while stalled.
- Reset mid-stream: assert rst with 2 transactions in flight -> the next cycle out_valid=0, and those transactions never appear.
- With ADD_SUB_RANGE_CHECK_EN: lane 2 a=3329 -> err=1 next cycle and stays 1 until rst; further valid traffic does not clear it.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types. DATA_WIDTH and Q come from the
// `DATA_WIDTH / `Q macros when defined, else default to Kyber-style 12 / 3329.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

package ntt_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int Q          = `Q;

    typedef logic [DATA_WIDTH-1:0] coef_t;

    typedef enum logic {
        BF_NTT  = 1'b0,
        BF_INTT = 1'b1
    } bf_mode_t;

endpackage

// File: rtl/add_sub_array_if.sv
// Valid/ready bus of the butterfly add/sub array: the input transaction and
// the result channel. The master side is upstream+downstream, the slave side the array.
interface add_sub_array_if
    import ntt_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH
);

    logic                             in_valid;
    logic                             in_ready;
    bf_mode_t                         in_mode;
    logic [LANES-1:0][DATA_WIDTH-1:0] in_a;
    logic [LANES-1:0][DATA_WIDTH-1:0] in_b;

    logic                             out_valid;
    logic                             out_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0] out_sum;
    logic [LANES-1:0][DATA_WIDTH-1:0] out_diff;

    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_diff
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_diff
    );

endinterface

// File: rtl/add_sub_lane.sv
// One butterfly lane: S1 computes (a+b) mod Q and (a-b) mod Q, S2 optionally
// halves both mod Q for INTT. Pure datapath; the array owns the handshake.
module add_sub_lane
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
    parameter int Q          = ntt_pkg::Q
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  bf_mode_t              i_mode,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic [DATA_WIDTH-1:0] o_diff
);

    localparam logic [DATA_WIDTH-1:0] Q_W       = DATA_WIDTH'(Q);
    localparam logic [DATA_WIDTH-1:0] Q_HALF_UP = DATA_WIDTH'((Q + 1) / 2);

    // For odd x and odd Q, (x+Q)/2 == (x-1)/2 + (Q+1)/2, which never leaves
    // DATA_WIDTH bits; even x is simply shifted.
    function automatic logic [DATA_WIDTH-1:0] half_mod(input logic [DATA_WIDTH-1:0] x);
        return {1'b0, x[DATA_WIDTH-1:1]} + (x[0] ? Q_HALF_UP : '0);
    endfunction

    logic                  w_sum_carry;
    logic [DATA_WIDTH-1:0] w_sum_lo;
    logic [DATA_WIDTH-1:0] w_s1_sum;
    logic                  w_diff_borrow;
    logic [DATA_WIDTH-1:0] w_diff_lo;
    logic [DATA_WIDTH-1:0] w_s1_diff;
    logic [DATA_WIDTH-1:0] w_s2_sum;
    logic [DATA_WIDTH-1:0] w_s2_diff;

    logic [DATA_WIDTH-1:0] r_s;
    logic [DATA_WIDTH-1:0] r_d;
    bf_mode_t              r_mode;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_diff;

    // DATA_WIDTH+1-bit sum/difference; the extra bit only steers the
    // correction, since the corrected result always fits DATA_WIDTH bits.
    assign {w_sum_carry, w_sum_lo}    = {1'b0, i_a} + {1'b0, i_b};
    assign {w_diff_borrow, w_diff_lo} = {1'b0, i_a} - {1'b0, i_b};

    assign w_s1_sum  = (w_sum_carry || (w_sum_lo >= Q_W)) ? w_sum_lo - Q_W : w_sum_lo;
    assign w_s1_diff = w_diff_borrow ? w_diff_lo + Q_W : w_diff_lo;

    assign w_s2_sum  = (r_mode == BF_INTT) ? half_mod(r_s) : r_s;
    assign w_s2_diff = (r_mode == BF_INTT) ? half_mod(r_d) : r_d;

    // NOTE: data registers are reset as well because the result ports must
    // read 0 after reset; stage contents otherwise only matter behind a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_d    <= '0;
            r_mode <= BF_NTT;
            r_sum  <= '0;
            r_diff <= '0;
        end else if (i_en) begin
            r_s    <= w_s1_sum;
            r_d    <= w_s1_diff;
            r_mode <= i_mode;
            r_sum  <= w_s2_sum;
            r_diff <= w_s2_diff;
        end
    end

    assign o_sum  = r_sum;
    assign o_diff = r_diff;

endmodule

// File: rtl/add_sub_array.sv
// LANES-wide two-stage modular butterfly add/sub with valid/ready backpressure.
// Optional sticky input range error port under macro ADD_SUB_RANGE_CHECK_EN.
module add_sub_array
    import ntt_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
    parameter int Q          = ntt_pkg::Q
) (
    input  logic               clk,
    input  logic               rst,
    add_sub_array_if.slave     bus
`ifdef ADD_SUB_RANGE_CHECK_EN
    ,
    output logic               err
`endif
);

    logic w_en;
    logic r_s1_valid;
    logic r_out_valid;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_out_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_out_valid <= r_s1_valid;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        add_sub_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .Q          (Q)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_mode (bus.in_mode),
            .i_a    (bus.in_a[g]),
            .i_b    (bus.in_b[g]),
            .o_sum  (bus.out_sum[g]),
            .o_diff (bus.out_diff[g])
        );
    end

`ifdef ADD_SUB_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] Q_W = DATA_WIDTH'(Q);

    logic w_range_bad;
    logic r_err;

    // NOTE: a combinational block assigns its outputs a default first so no
    // path through it leaves them unassigned and infers a latch.
    always_comb begin
        w_range_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ((bus.in_a[i] >= Q_W) || (bus.in_b[i] >= Q_W)) begin
                w_range_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.in_valid && w_en && w_range_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_add_sub_array.sv
// Scoreboard bench for add_sub_array (Q=3329, DATA_WIDTH=12, LANES=4):
// directed butterfly vectors, latency, backpressure, mid-stream reset, range error.
module tb_add_sub_array;
    import ntt_pkg::*;

    localparam int LANES = 4;
    localparam int DW    = DATA_WIDTH;

    typedef logic [LANES-1:0][DW-1:0] vec_t;
    typedef struct packed {
        logic dc;
        vec_t sum;
        vec_t diff;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_sub_array_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus ();

`ifdef ADD_SUB_RANGE_CHECK_EN
    logic err;
    add_sub_array #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus), .err(err));
`else
    add_sub_array #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Hand-computed rows, [mode][row]: mode 0 = NTT, 1 = INTT.
    int tbl_a    [2][4] = '{'{3000, 0,    3328, 1664}, '{3,    0,    3328, 1664}};
    int tbl_b    [2][4] = '{'{1000, 1,    3328, 1665}, '{0,    1,    3328, 1665}};
    int tbl_sum  [2][4] = '{'{671,  1,    3327, 0   }, '{1666, 1665, 3328, 0   }};
    int tbl_diff [2][4] = '{'{2000, 3328, 0,    3328}, '{1666, 1664, 0,    1664}};

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_rx     = 0;
    resp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_vec(input bf_mode_t mode, input vec_t a, input vec_t b, input resp_t exp);
        int waited;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        waited = 0;
        while (!bus.in_ready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 50) begin
                check("in_ready_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Lane l takes table row (l+rot)%4 of the chosen mode.
    task automatic send(input bf_mode_t mode, input int rot);
        vec_t  a, b;
        resp_t e;
        int    m;
        m    = (mode == BF_INTT) ? 1 : 0;
        e.dc = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            a[l]      = DW'(tbl_a[m][(l + rot) % 4]);
            b[l]      = DW'(tbl_b[m][(l + rot) % 4]);
            e.sum[l]  = DW'(tbl_sum[m][(l + rot) % 4]);
            e.diff[l] = DW'(tbl_diff[m][(l + rot) % 4]);
        end
        send_vec(mode, a, b, e);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares the queue head whenever a result is presented, so a
    // stalled result is re-checked every cycle; pops on the actual transfer.
    initial begin : monitor
        resp_t e;
        logic  ok;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    if (!e.dc) begin
                        check("out_sum", 64'(bus.out_sum), 64'(e.sum));
                        check("out_diff", 64'(bus.out_diff), 64'(e.diff));
                        ok = 1'b1;
                        for (int l = 0; l < LANES; l++) begin
                            if (bus.out_sum[l] >= DW'(Q) || bus.out_diff[l] >= DW'(Q)) ok = 1'b0;
                        end
                        check("below_q", 64'(ok), 64'd1);
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_rx++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int rx_before;
        int stall_cnt;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = BF_NTT;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_sum", 64'(bus.out_sum), 64'd0);
        check("reset_out_diff", 64'(bus.out_diff), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef ADD_SUB_RANGE_CHECK_EN
        check("reset_err", 64'(err), 64'd0);
`endif

        // Latency: accepted at edge k, out_valid rises after edge k+1.
        send(BF_NTT, 0);
        @(negedge clk);
        #1;
        check("latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("latency_cycle2", 64'(bus.out_valid), 64'd1);
        drain();

        // Every table row through every lane, back to back.
        for (int r = 0; r < 4; r++) send(BF_NTT, r);
        for (int r = 0; r < 4; r++) send(BF_INTT, r);
        drain();

        // Backpressure: alternating modes, out_ready low for cycles 3..6.
        rx_before = n_rx;
        stall_cnt = 0;
        fork
            begin
                for (int t = 0; t < 8; t++) send((t % 2) ? BF_INTT : BF_NTT, t);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    bus.out_ready = !(c >= 3 && c <= 6);
                    #1;
                    if (!bus.in_ready) stall_cnt++;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("bp_in_ready_dropped", 64'(stall_cnt > 0), 64'd1);
        check("bp_rx_count", 64'(n_rx - rx_before), 64'd8);

        // Mid-stream reset with two transactions in flight.
        send(BF_NTT, 1);
        send(BF_INTT, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (4) @(negedge clk);
        rx_before = n_rx;
        send(BF_INTT, 3);
        drain();
        check("post_rst_rx_count", 64'(n_rx - rx_before), 64'd1);

`ifdef ADD_SUB_RANGE_CHECK_EN
        begin
            vec_t  a, b;
            resp_t e;
            a    = '0;
            b    = '0;
            a[2] = DW'(3329);
            e    = '0;
            e.dc = 1'b1;
            check("err_before", 64'(err), 64'd0);
            send_vec(BF_NTT, a, b, e);
            check("err_set", 64'(err), 64'd1);
            send(BF_NTT, 0);
            send(BF_INTT, 1);
            drain();
            check("err_sticky", 64'(err), 64'd1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("err_cleared", 64'(err), 64'd0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
